imm_instr_encoder: RTL

- Takes a symbolic immediate-format request and emits 32-bit instruction words that the immediate-format decode path accepts unchanged.
- Covered requests: opcode, Rd, Rn, immediate and halfword select.
- Also expands a 64-bit load-constant pseudo-op into a MOVZ/MOVK sequence.
- Sits between the test/boot loader and instruction memory. Output is a valid/ready word stream, one word per accepted beat.

---
 rtl/imm_instr_encoder_if.sv | 26 ++
 rtl/imm_instr_encoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/imm_instr_encoder_if.sv
// Request / word-stream bundle between the loader (master) and the immediate encoder (slave).
interface imm_instr_encoder_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op_in;
  logic [4:0]      rd_in;
  logic [4:0]      rn_in;
  logic [XLEN-1:0] imm_in;
  logic [1:0]      hw_in;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     instr_out;
  logic            out_last;

  modport master (
    output in_valid, op_in, rd_in, rn_in, imm_in, hw_in, out_ready,
    input  in_ready, out_valid, instr_out, out_last
  );

  modport slave (
    input  in_valid, op_in, rd_in, rn_in, imm_in, hw_in, out_ready,
    output in_ready, out_valid, instr_out, out_last
  );
endinterface

// File: rtl/imm_instr_encoder.sv
// Encodes immediate-format requests into 32-bit instruction words; LDC expands
// into MOVZ followed by MOVKs for the upper halfwords.
//
// state     | meaning
// S_IDLE    | no word pending, ready for a request
// S_EMIT    | holding the final (or only) word of a request
// S_LDC_SEQ | holding a non-final word of an LDC expansion
module imm_instr_encoder #(
  parameter int XLEN         = 64,
  parameter bit SKIP_ZERO_HW = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  imm_instr_encoder_if.slave  bus,
  output logic                err,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EMIT    = 2'd1,
    S_LDC_SEQ = 2'd2
  } state_t;

  localparam logic [3:0] OP_MOVZ = 4'd10;
  localparam logic [3:0] OP_MOVK = 4'd11;
  localparam logic [3:0] OP_LDC  = 4'd12;

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_acc_state;

  logic        r_out_valid;
  logic [31:0] r_instr;
  logic        r_last;
  logic        r_err;
  logic [47:0] r_const_hi;
  logic [4:0]  r_rd;
  logic [2:0]  r_mask;

  logic [63:0] w_imm64;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_illegal;
  logic        w_is_ldc;
  logic [2:0]  w_hw_nz;
  logic [2:0]  w_mask_init;
  logic [31:0] w_acc_word;
  logic        w_acc_last;
  logic [1:0]  w_next_hw;
  logic [2:0]  w_mask_rest;
  logic [15:0] w_const_hw;

  function automatic logic [31:0] f_mov(input logic k, input logic [1:0] hw,
                                        input logic [15:0] imm, input logic [4:0] rd);
    return {2'b11, k, 6'b100101, hw, imm, rd};
  endfunction

  function automatic logic [31:0] f_enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [63:0] imm,
                                        input logic [1:0] hw);
    logic [31:0] w;
    w = 32'd0;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: w = {1'b1, op[1:0], 5'b10001, 2'b00, imm[11:0], rn, rd};
      4'd4, 4'd5, 4'd6, 4'd7: w = {1'b1, op[1:0], 7'b1001000, imm[11:0], rn, rd};
      4'd8, 4'd9:             w = {3'b110, 7'b1001101, (op == 4'd8), 5'd0, imm[5:0], rn, rd};
      OP_MOVZ:                w = f_mov(1'b0, hw, imm[15:0], rd);
      OP_MOVK:                w = f_mov(1'b1, hw, imm[15:0], rd);
      default:                w = 32'd0;
    endcase
    return w;
  endfunction

  // Constants narrower than 64 bits are zero-extended; wider ones are truncated.
  generate
    if (XLEN >= 64) begin : g_imm_trunc
      assign w_imm64 = bus.imm_in[63:0];
    end else begin : g_imm_ext
      assign w_imm64 = {{(64 - XLEN){1'b0}}, bus.imm_in};
    end
  endgenerate

  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_illegal   = (bus.op_in > OP_LDC);
  assign w_is_ldc    = (bus.op_in == OP_LDC);
  assign w_hw_nz     = {|w_imm64[63:48], |w_imm64[47:32], |w_imm64[31:16]};
  assign w_mask_init = SKIP_ZERO_HW ? w_hw_nz : 3'b111;

  assign w_acc_word  = w_is_ldc ? f_mov(1'b0, 2'd0, w_imm64[15:0], bus.rd_in)
                                : f_enc(bus.op_in, bus.rd_in, bus.rn_in, w_imm64, bus.hw_in);
  assign w_acc_last  = w_is_ldc ? (w_mask_init == 3'b000) : 1'b1;
  assign w_acc_state = w_illegal ? S_IDLE :
                       (w_is_ldc && (w_mask_init != 3'b000)) ? S_LDC_SEQ : S_EMIT;

  // MOVKs go out in ascending hw order: always take the lowest pending halfword.
  always_comb begin
    w_next_hw  = 2'd3;
    if (r_mask[0])      w_next_hw = 2'd1;
    else if (r_mask[1]) w_next_hw = 2'd2;
    w_mask_rest = r_mask & ~(3'b001 << (w_next_hw - 2'd1));
    case (w_next_hw)
      2'd1:    w_const_hw = r_const_hi[15:0];
      2'd2:    w_const_hw = r_const_hi[31:16];
      default: w_const_hw = r_const_hi[47:32];
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = w_acc_state;
      S_EMIT:    if (bus.out_ready) w_state_nxt = w_accept ? w_acc_state : S_IDLE;
      S_LDC_SEQ: if (bus.out_ready && (w_mask_rest == 3'b000)) w_state_nxt = S_EMIT;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // A draining final word frees the output register in the same cycle.
  always_comb begin
    w_in_ready = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE:  begin w_in_ready = 1'b1; busy = 1'b0; end
      S_EMIT:  w_in_ready = bus.out_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_instr     <= 32'd0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_const_hi  <= 48'd0;
      r_rd        <= 5'd0;
      r_mask      <= 3'd0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (w_illegal) begin
          r_out_valid <= 1'b0;
          r_err       <= 1'b1;
        end else begin
          r_out_valid <= 1'b1;
          r_instr     <= w_acc_word;
          r_last      <= w_acc_last;
        end
        if (w_is_ldc) begin
          r_const_hi <= w_imm64[63:16];
          r_rd       <= bus.rd_in;
          r_mask     <= w_mask_init;
        end
      end else if (r_out_valid && bus.out_ready) begin
        if (r_state == S_LDC_SEQ) begin
          r_instr <= f_mov(1'b1, w_next_hw, w_const_hw, r_rd);
          r_mask  <= w_mask_rest;
          r_last  <= (w_mask_rest == 3'b000);
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.instr_out = r_instr;
  assign bus.out_last  = r_last;
  assign err           = r_err;

endmodule
